fir_mac_seq: RTL and testbench
==============================

# fir_mac_seq

Sequential multiply-accumulate engine that sits directly downstream of the 16-bit tapped delay line in the FIR datapath. On each new-sample strobe it snapshots all N taps and multiplies them against N locally stored Q1.15 coefficients, one product per cycle on a single multiplier. It then rounds and saturates the sum to a 16-bit Q1.15 filter output with a one-cycle valid pulse. Coefficients are loaded through a simple write port while the engine is idle.

## Interface
- N, 8, number of taps/coefficients (≥2)
- ACC_W, 32+$clog2(N), accumulator width (signed)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- taps  input  16*N  delay-line contents, flattened; tap k = taps[16k+15:16k], tap 0 newest, signed Q1.15
- start  input  1  one-cycle strobe: taps hold a new sample set
- coef_we  input  1  coefficient write enable
- coef_addr  input  $clog2(N)  coefficient index
- coef_data  input  16  coefficient value, signed Q1.15
- y_out  output  16  filter output, signed Q1.15, held until next result
- y_valid  output  1  one-cycle pulse: y_out updated
- busy  output  1  high while a computation is in progress
- overrun  output  1  sticky: start arrived while busy

## Operation
- Reset (rst high at clock edge): state IDLE; y_out=0, y_valid=0, busy=0, overrun=0; all coefficients=0; accumulator, index and snapshot cleared.
- States: IDLE → MAC → OUT → IDLE.
- IDLE: on start=1 capture all N taps into a snapshot register, clear the accumulator, set index=0, and go to MAC. busy is 1 from the next cycle.
- MAC: each cycle acc += sext(snap[idx]*coef[idx]). The product is 32-bit signed, sign-extended to ACC_W. idx increments. After the cycle with idx=N-1, go to OUT. Runs exactly N cycles.
- OUT: r = (acc + 2^14) >>> 15 (arithmetic shift, round half up). If r > 32767 then y_out=0x7FFF. If r < -32768 then y_out=0x8000. Otherwise y_out=r[15:0]. Pulse y_valid and return to IDLE. The accumulator never overflows internally for any inputs at the default ACC_W.
- The snapshot isolates the computation from the delay line shifting mid-computation.
- start while in MAC or OUT: ignored (no restart, no queueing) and overrun set to 1. overrun clears only on rst.
- Coefficient writes: applied only in IDLE, including the same cycle as a start; the write is visible to that computation. Writes while busy are dropped. A write with coef_addr ≥ N is dropped.
- Reset mid-computation aborts immediately. y_valid does not fire for the aborted computation.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1..N: MAC, busy=1.
- Cycle N+1: OUT, busy=1.
- y_out/y_valid registered at the end of OUT, so y_valid=1 and new y_out appear in cycle N+2; busy=0 in cycle N+2.
- Start latency to y_valid: N+2 cycles. Minimum start spacing for no overrun: N+2 cycles. A start in cycle N+2 is accepted.
- y_valid is exactly one cycle wide. y_out is stable between pulses.
- Coefficient write in cycle t is visible to a start in cycle t or later.

## Test plan
- Identity: coef[0]=0x7FFF, others 0; taps all 0 except tap0=1000; start → y_valid exactly 10 cycles later (N=8), y_out=1000, busy high cycles 1–9.
- Rounding: coef[0]=0x4000, tap0=0x0001, others 0 → y_out=0x0001. Then coef[0]=0x3FFF, same taps → y_out=0x0000.
- Positive saturation: all coef=0x4000, all taps=0x2000 → y_out=0x7FFF. Negative saturation: all coef=0x7FFF, all taps=0x8000 → y_out=0x8000.
- Snapshot/overrun: start, then change taps and pulse start again in cycle 3 → first result computed from the original taps, only one y_valid, overrun=1 and stays 1 until rst. A start in cycle N+2 is accepted without setting overrun.
- Coefficient gating: coef_we while busy (addr 0, 0x7FFF) → no effect on the next result. coef_addr ≥ N → dropped. A write in the start cycle is used.
- Reset mid-MAC: assert rst in cycle 4 → no y_valid, y_out=0, busy=0, coefficients=0. A following start yields y_out=0.

Source files
------------

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential single-multiplier FIR multiply-accumulate engine
// Snapshots N taps on start, accumulates N products one per cycle, then rounds and saturates to Q1.15.
module fir_mac_seq #(
    parameter int N     = 8,
    parameter int ACC_W = 32 + $clog2(N)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [16*N-1:0]        taps_i,
    input  logic                   start_i,
    input  logic                   coef_we_i,
    input  logic [$clog2(N)-1:0]   coef_addr_i,
    input  logic [15:0]            coef_data_i,
    output logic [15:0]            y_out_o,
    output logic                   y_valid_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int IDX_W = $clog2(N);
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(16384);
    localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] Y_MIN    = ACC_W'(-32768);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                  state_q;
    logic signed [15:0]      snap_q [N];
    logic signed [15:0]      coef_q [N];
    logic [IDX_W-1:0]        idx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] rnd;
    logic [15:0]             y_d;
    logic                    addr_ok;
    logic [15:0]             y_out_q;
    logic                    y_valid_q;
    logic                    busy_q;
    logic                    overrun_q;

    assign addr_ok = (int'(coef_addr_i) < N);

    always_comb begin
        prod  = snap_q[idx_q] * coef_q[idx_q];
        acc_d = acc_q + ACC_W'(prod);
        // Round half up, then clamp to the Q1.15 range.
        rnd   = (acc_q + HALF_LSB) >>> 15;
        y_d   = rnd[15:0];
        if (rnd > Y_MAX) begin
            y_d = 16'h7FFF;
        end else if (rnd < Y_MIN) begin
            y_d = 16'h8000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (coef_we_i && addr_ok) begin
                        coef_q[coef_addr_i] <= coef_data_i;
                    end
                    if (start_i) begin
                        for (int k = 0; k < N; k++) begin
                            snap_q[k] <= taps_i[16*k +: 16];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    y_out_q   <= y_d;
                    y_valid_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // A start that arrives while a result is being produced is dropped but remembered.
            if (start_i && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign y_out_o   = y_out_q;
    assign y_valid_o = y_valid_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - self-checking bench for fir_mac_seq
module tb_fir_mac_seq;

    localparam int N = 8;
    localparam int W = 16 * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   taps = '0;
    logic           start = 1'b0;
    logic           coef_we = 1'b0;
    logic [2:0]     coef_addr = '0;
    logic [15:0]    coef_data = '0;
    logic [15:0]    y_out;
    logic           y_valid;
    logic           busy;
    logic           overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] y;
        int          c;
    } sb_t;

    typedef struct {
        logic [W-1:0] cf;
        logic [W-1:0] tp;
        logic [15:0]  y;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t tbl[10];

    fir_mac_seq #(.N(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .taps_i      (taps),
        .start_i     (start),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .y_out_o     (y_out),
        .y_valid_o   (y_valid),
        .busy_o      (busy),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && y_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got y_valid=1 y_out=%h at cycle %0d, required no pulse", y_out, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("y_out", {16'h0, y_out}, {16'h0, mon_e.y});
                check("latency", cyc - mon_e.c, N + 2);
            end
        end
    end

    function automatic logic [15:0] model(input logic [W-1:0] cf, input logic [W-1:0] tp);
        longint acc = 0;
        longint r;
        for (int k = 0; k < N; k++) begin
            acc += longint'($signed(cf[16*k +: 16])) * longint'($signed(tp[16*k +: 16]));
        end
        r = (acc + 16384) >>> 15;
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] cf);
        for (int k = 0; k < N; k++) wr_coef(3'(k), cf[16*k +: 16]);
    endtask

    task automatic fire(input logic [W-1:0] tp, input logic [15:0] y);
        sb_t e;
        taps = tp;
        start = 1'b1;
        e.y = y;
        e.c = cyc;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (sb_q.size() != 0 && b < 40) begin
            tick();
            b++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
        tick();
    endtask

    initial begin
        logic [W-1:0] cf, tp;

        tbl[0] = '{W'(16'h7FFF), W'(16'd1000), 16'd1000};
        tbl[1] = '{W'(16'h4000), W'(16'h0001), 16'h0001};
        tbl[2] = '{W'(16'h3FFF), W'(16'h0001), 16'h0000};
        tbl[3] = '{{N{16'h4000}}, {N{16'h2000}}, 16'h7FFF};
        tbl[4] = '{{N{16'h7FFF}}, {N{16'h8000}}, 16'h8000};
        tbl[5] = '{W'(16'h4000), W'(16'hFFFF), 16'h0000};
        tbl[6] = '{W'(16'h4000), W'(16'hFFFD), 16'hFFFF};
        tbl[7] = '{{N{16'h4000}},
                   {16'd800, 16'd700, 16'd600, 16'd500, 16'd400, 16'd300, 16'd200, 16'd100},
                   16'd1800};
        tbl[8] = '{{N{16'h2000}}, {N{16'hFC18}}, 16'hF830};
        tbl[9] = '{W'(16'h7FFF), W'(16'h7FFF), 16'h7FFE};

        repeat (3) tick();
        check("rst_y_out", {16'h0, y_out}, 32'h0);
        check("rst_y_valid", {31'h0, y_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            load(tbl[i].cf);
            fire(tbl[i].tp, tbl[i].y);
            drain();
        end

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) begin
                cf[16*k +: 16] = 16'($urandom);
                tp[16*k +: 16] = 16'($urandom);
            end
            load(cf);
            fire(tp, model(cf, tp));
            drain();
        end

        // Identity run with busy profile over cycles 1..10
        load(W'(16'h7FFF));
        fire(W'(16'd1000), 16'd1000);
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("busy_c%0d", k), {31'h0, busy}, (k <= 9) ? 32'h1 : 32'h0);
            tick();
        end
        drain();

        // Snapshot isolation and overrun on a start in cycle 3
        fire(W'(16'd1000), 16'd1000);
        tick();
        tick();
        taps = W'(16'd5000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("overrun_set", {31'h0, overrun}, 32'h1);
        drain();
        repeat (5) tick();
        check("overrun_sticky", {31'h0, overrun}, 32'h1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("overrun_cleared", {31'h0, overrun}, 32'h0);

        // Start in cycle N+2 is accepted without overrun
        load(W'(16'h7FFF));
        fire(W'(16'd1000), 16'd1000);
        repeat (N + 1) tick();
        fire(W'(16'd2000), 16'd2000);
        drain();
        check("b2b_no_overrun", {31'h0, overrun}, 32'h0);

        // Coefficient gating
        load(W'(16'h4000));
        fire(W'(16'd1000), 16'd500);
        tick();
        wr_coef(3'd0, 16'h7FFF);
        drain();
        fire(W'(16'd1000), 16'd500);
        drain();
        coef_we = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'h7FFF;
        fire(W'(16'd1000), 16'd1000);
        coef_we = 1'b0;
        drain();

        // Reset in cycle 4 aborts the computation
        fire(W'(16'd1000), 16'd1000);
        repeat (3) tick();
        sb_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("abort_y_out", {16'h0, y_out}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_overrun", {31'h0, overrun}, 32'h0);
        fire(W'(16'd1000), 16'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
